pbit_gibbs_sampler: RTL and testbench
=====================================

PBIT_GIBBS_SAMPLER -- requirements
Module: pbit_gibbs_sampler

Interface
REQ-001 SHALL have parameter N_PBITS, default 4: number of p-bit nodes (1..64).
REQ-002 SHALL have parameter LFSR_SEED, default 16'hACE1: LFSR reset value; a value of 0 SHALL be replaced by 16'h0001.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1: single-cycle request to begin a sampling run.
REQ-006 SHALL have port num_sweeps, input, 8: sweeps per run, sampled with start.
REQ-007 SHALL have port beta, input, 3: inverse temperature (0..7), sampled with start.
REQ-008 SHALL have port act_in, input, 4*N_PBITS: packed signed 4-bit activations from the gate network, node i at [4i+3:4i].
REQ-009 SHALL have port clamp_mask, input, N_PBITS: 1 = node held at clamp_val and never sampled.
REQ-010 SHALL have port clamp_val, input, N_PBITS: value forced on clamped nodes.
REQ-011 SHALL have port state, output, N_PBITS: registered binary node states, fed back to the gate network.
REQ-012 SHALL have port busy, output, 1: high in UPDATE.
REQ-013 SHALL have port done, output, 1: one-cycle pulse at end of run.
REQ-014 SHALL have port sweep_cnt, output, 8: completed sweeps in the current or last run.

Function
REQ-015 SHALL implement FSM states IDLE, UPDATE, DONE.
REQ-016 In IDLE, start=1 SHALL latch num_sweeps and beta, clear sweep_cnt and idx, and go to UPDATE, or go to DONE if num_sweeps=0.
REQ-017 start SHALL be ignored outside IDLE.
REQ-018 UPDATE SHALL visit one node per cycle, idx 0..N_PBITS-1 ascending, so act_in reflects all prior updates (single-site Gibbs).
REQ-019 Scaled activation SHALL be a_s = act_in[idx]*beta_eff, computed at full width and saturated to [-8,+8].
REQ-020 An unclamped node SHALL update to state[idx] <= ((a_s+8) > rnd), where rnd = lfsr[3:0] unsigned, giving P(1) = (a_s+8)/16; a_s=+8 SHALL always give 1 and a_s=-8 SHALL always give 0.
REQ-021 A clamped node SHALL update to state[idx] <= clamp_val[idx] when visited; in every cycle in IDLE, clamped bits SHALL be forced as well.
REQ-022 The LFSR SHALL be 16-bit Fibonacci with taps 16,14,13,11 and SHALL advance once per UPDATE cycle only.
REQ-023 At idx=N_PBITS-1, sweep_cnt SHALL increment; if the new count equals the latched num_sweeps the FSM SHALL go to DONE, else idx SHALL wrap to 0.
REQ-024 DONE SHALL assert done for exactly one cycle and then return to IDLE; latency from the start edge to the done cycle SHALL be N_PBITS*num_sweeps+1 cycles.
REQ-025 state and sweep_cnt SHALL hold their values in IDLE and DONE, apart from clamping.

Reset
REQ-026 On rst, state, busy, done, sweep_cnt and idx SHALL be 0, the FSM SHALL be IDLE, and the LFSR SHALL be LFSR_SEED.
REQ-027 rst SHALL take priority over start and abort any run in progress without a done pulse.

Configuration
REQ-028 With macro PBIT_ANNEAL_EN defined, beta_eff SHALL start at the latched beta and increment by 1 after each completed sweep, saturating at 7.
REQ-029 Without PBIT_ANNEAL_EN, beta_eff SHALL equal the latched beta for the whole run, and no increment logic SHALL exist.

Verification
REQ-030 Reset: assert rst for 2 cycles -> state=0, busy=0, done=0, sweep_cnt=0, LFSR=16'hACE1.
REQ-031 N=4, beta=7, act_in all +2, mask=0, num_sweeps=1, start -> state=4'b1111, done pulses 5 cycles after start, sweep_cnt=1.
REQ-032 Same as REQ-031 with act_in all -2 -> state=4'b0000.
REQ-033 act_in all +7, beta=7, clamp_mask=4'b0101, clamp_val=4'b0001, 2 sweeps -> state=4'b1011, done 9 cycles after start.
REQ-034 num_sweeps=0, start -> done the next cycle, busy never high, state unchanged; start during busy -> ignored, sweep count unaffected.
REQ-035 N=1, beta=0, 255 sweeps, count ones across per-sweep samples -> 128+/-40; rst asserted mid-run -> IDLE next cycle, no done pulse.

Source files
------------

// File: rtl/pbit_gibbs_sampler.sv
// Single-site Gibbs sampler over N_PBITS probabilistic bits driven by an LFSR.
// Optional build macro PBIT_ANNEAL_EN: beta_eff steps up by one per completed sweep (saturating at 7).
module pbit_gibbs_sampler #(
    parameter int          N_PBITS   = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             num_sweeps,
    input  logic [2:0]             beta,
    input  logic [4*N_PBITS-1:0]   act_in,
    input  logic [N_PBITS-1:0]     clamp_mask,
    input  logic [N_PBITS-1:0]     clamp_val,
    output logic [N_PBITS-1:0]     state,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             sweep_cnt
);

    localparam int                 IDX_W    = (N_PBITS > 1) ? $clog2(N_PBITS) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_PBITS - 1);
    localparam logic [15:0]        SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } fsm_t;

    fsm_t                 r_fsm;
    fsm_t                 w_fsm_next;
    logic [IDX_W-1:0]     r_idx;
    logic [7:0]           r_num_sweeps;
    logic [7:0]           r_sweep_cnt;
    logic [2:0]           r_beta;
    logic [15:0]          r_lfsr;
    logic [N_PBITS-1:0]   r_state;
    logic                 r_busy;
    logic                 r_done;

    logic signed [3:0]    w_act;
    logic                 w_clamp_m;
    logic                 w_clamp_v;
    logic signed [4:0]    w_as;
    logic [4:0]           w_thresh;
    logic                 w_new_bit;
    logic                 w_last;
    logic [7:0]           w_sweep_inc;
    logic [N_PBITS-1:0]   w_state_upd;

    // Fibonacci LFSR, taps 16,14,13,11
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Product of signed activation and unsigned beta, clipped to [-8,+8]
    function automatic logic signed [4:0] scale_sat(input logic signed [3:0] a, input logic [2:0] b);
        logic signed [7:0] p;
        p = 8'(a) * 8'($signed({1'b0, b}));
        if (p > 8'sd8) begin
            return 5'sd8;
        end else if (p < -8'sd8) begin
            return -5'sd8;
        end else begin
            return p[4:0];
        end
    endfunction

    // Select the activation and clamp controls of the node being visited
    always_comb begin
        w_act     = 4'sd0;
        w_clamp_m = 1'b0;
        w_clamp_v = 1'b0;
        for (int i = 0; i < N_PBITS; i++) begin
            if (IDX_W'(i) == r_idx) begin
                w_act     = act_in[4*i +: 4];
                w_clamp_m = clamp_mask[i];
                w_clamp_v = clamp_val[i];
            end else begin
                w_act     = w_act;
            end
        end
    end

    // Stochastic decision: P(1) = (a_s + 8) / 16 against the low LFSR nibble
    always_comb begin
        w_as        = scale_sat(w_act, r_beta);
        w_thresh    = $unsigned(w_as + 5'sd8);
        w_new_bit   = w_clamp_m ? w_clamp_v : (w_thresh > {1'b0, r_lfsr[3:0]});
        w_last      = (r_idx == LAST_IDX);
        w_sweep_inc = r_sweep_cnt + 8'd1;
    end

    // Next state vector after writing the visited node
    always_comb begin
        w_state_upd = r_state;
        for (int i = 0; i < N_PBITS; i++) begin
            if (IDX_W'(i) == r_idx) begin
                w_state_upd[i] = w_new_bit;
            end else begin
                w_state_upd[i] = r_state[i];
            end
        end
    end

    // FSM next-state logic
    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            ST_IDLE: begin
                if (start) begin
                    w_fsm_next = (num_sweeps == 8'd0) ? ST_DONE : ST_UPDATE;
                end else begin
                    w_fsm_next = ST_IDLE;
                end
            end
            ST_UPDATE: begin
                if (w_last && (w_sweep_inc == r_num_sweeps)) begin
                    w_fsm_next = ST_DONE;
                end else begin
                    w_fsm_next = ST_UPDATE;
                end
            end
            ST_DONE:  w_fsm_next = ST_IDLE;
            default:  w_fsm_next = ST_IDLE;
        endcase
    end

    // State register, run bookkeeping and node updates
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm        <= ST_IDLE;
            r_idx        <= '0;
            r_num_sweeps <= 8'd0;
            r_sweep_cnt  <= 8'd0;
            r_beta       <= 3'd0;
            r_lfsr       <= SEED_EFF;
            r_state      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_fsm  <= w_fsm_next;
            r_busy <= (w_fsm_next == ST_UPDATE);
            r_done <= (w_fsm_next == ST_DONE);
            case (r_fsm)
                ST_IDLE: begin
                    r_state <= (r_state & ~clamp_mask) | (clamp_val & clamp_mask);
                    if (start) begin
                        r_num_sweeps <= num_sweeps;
                        r_beta       <= beta;
                        r_sweep_cnt  <= 8'd0;
                        r_idx        <= '0;
                    end
                end
                ST_UPDATE: begin
                    r_lfsr  <= lfsr_step(r_lfsr);
                    r_state <= w_state_upd;
                    if (w_last) begin
                        r_sweep_cnt <= w_sweep_inc;
                        r_idx       <= '0;
`ifdef PBIT_ANNEAL_EN
                        if (r_beta != 3'd7) begin
                            r_beta <= r_beta + 3'd1;
                        end
`endif
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign state     = r_state;
    assign busy      = r_busy;
    assign done      = r_done;
    assign sweep_cnt = r_sweep_cnt;

endmodule

// File: tb/tb_pbit_gibbs_sampler.sv
// Scoreboard bench: directed runs on a 4-node and a 1-node sampler.
`timescale 1ns/1ps
module tb_pbit_gibbs_sampler;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start;
    logic [7:0]  num_sweeps;
    logic [2:0]  beta;
    logic [15:0] act_in;
    logic [3:0]  clamp_mask, clamp_val;
    logic [3:0]  state;
    logic        busy, done;
    logic [7:0]  sweep_cnt;

    logic        rst1, start1;
    logic [7:0]  num1;
    logic [2:0]  beta1;
    logic [3:0]  act1;
    logic [0:0]  cm1, cv1;
    logic [0:0]  state1;
    logic        busy1, done1;
    logic [7:0]  cnt1;

    pbit_gibbs_sampler #(.N_PBITS(4), .LFSR_SEED(16'hACE1)) dut4 (
        .clk(clk), .rst(rst), .start(start), .num_sweeps(num_sweeps), .beta(beta),
        .act_in(act_in), .clamp_mask(clamp_mask), .clamp_val(clamp_val),
        .state(state), .busy(busy), .done(done), .sweep_cnt(sweep_cnt));

    pbit_gibbs_sampler #(.N_PBITS(1), .LFSR_SEED(16'hACE1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .num_sweeps(num1), .beta(beta1),
        .act_in(act1), .clamp_mask(cm1), .clamp_val(cv1),
        .state(state1), .busy(busy1), .done(done1), .sweep_cnt(cnt1));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int d1_count = 0;

    typedef struct {
        logic [3:0] st;
        logic [7:0] cnt;
        int         done_cyc;
        string      name;
    } exp_t;
    exp_t sb_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Monitor: every done pulse of the 4-node sampler consumes one expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_state"},   32'(state),     32'(e.st));
                check({e.name, "_sweeps"},  32'(sweep_cnt), 32'(e.cnt));
                check({e.name, "_latency"}, 32'(cyc),       32'(e.done_cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst1 && done1 === 1'b1) d1_count <= d1_count + 1;
    end

    task automatic launch(input string name, input logic [7:0] ns, input logic [2:0] b,
                          input logic [15:0] act, input logic [3:0] cm, input logic [3:0] cv,
                          input logic [3:0] exp_st);
        exp_t e;
        @(negedge clk);
        num_sweeps = ns; beta = b; act_in = act; clamp_mask = cm; clamp_val = cv; start = 1'b1;
        e.st = exp_st; e.cnt = ns; e.done_cyc = cyc + 4 * int'(ns) + 1; e.name = name;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending done pulses expected 0", name, sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] m;
        int ones, ones_exp;

        rst = 1'b1; start = 1'b0; num_sweeps = 8'd0; beta = 3'd0; act_in = 16'h0000;
        clamp_mask = 4'h0; clamp_val = 4'h0;
        rst1 = 1'b1; start1 = 1'b0; num1 = 8'd0; beta1 = 3'd0; act1 = 4'h0; cm1 = 1'b0; cv1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state",  32'(state),     32'h0);
        check("rst_busy",   32'(busy),      32'h0);
        check("rst_done",   32'(done),      32'h0);
        check("rst_sweeps", 32'(sweep_cnt), 32'h0);
        check("rst_lfsr",   32'(dut4.r_lfsr), 32'hACE1);
        rst = 1'b0; rst1 = 1'b0;

        launch("pos2", 8'd1, 3'd7, 16'h2222, 4'h0, 4'h0, 4'b1111);
        wait_idle("pos2");
        check("hold_sweeps_idle", 32'(sweep_cnt), 32'd1);

        launch("neg2", 8'd1, 3'd7, 16'hEEEE, 4'h0, 4'h0, 4'b0000);
        wait_idle("neg2");

        launch("clamp", 8'd2, 3'd7, 16'h7777, 4'b0101, 4'b0001, 4'b1011);
        wait_idle("clamp");

        launch("zero", 8'd0, 3'd7, 16'h2222, 4'h0, 4'h0, 4'b1011);
        for (int k = 0; k < 3; k++) begin
            check("zero_busy", 32'(busy), 32'h0);
            @(negedge clk);
        end
        wait_idle("zero");

        launch("restart", 8'd3, 3'd7, 16'h2222, 4'h0, 4'h0, 4'b1111);
        repeat (4) @(negedge clk);
        check("restart_busy", 32'(busy), 32'h1);
        num_sweeps = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("restart");

        launch("mixed", 8'd1, 3'd2, 16'h4C4C, 4'h0, 4'h0, 4'b1010);
        wait_idle("mixed");

        // Reference: one LFSR draw per sweep, sample is 1 when rnd < 8 (a_s = 0)
        m = 16'hACE1;
        ones_exp = 0;
        for (int k = 0; k < 255; k++) begin
            if (m[3:0] < 4'd8) ones_exp++;
            m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
        end

        @(negedge clk);
        num1 = 8'd255; beta1 = 3'd0; act1 = 4'h5; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        ones = 0;
        for (int k = 0; k < 255; k++) begin
            @(posedge clk);
            #1;
            ones += int'(state1);
        end
        check("n1_done",   32'(done1), 32'h1);
        check("n1_sweeps", 32'(cnt1),  32'd255);
        check("n1_ones",   32'(ones),  32'(ones_exp));
        check("n1_ones_range", 32'((ones >= 88) && (ones <= 168)), 32'h1);

        @(negedge clk);
        @(negedge clk);
        num1 = 8'd10; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", 32'(busy1), 32'h1);
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        check("abort_busy",   32'(busy1), 32'h0);
        check("abort_done",   32'(done1), 32'h0);
        check("abort_sweeps", 32'(cnt1),  32'h0);
        repeat (20) @(negedge clk);
        check("abort_no_done", 32'(d1_count), 32'd1);
        check("abort_still_idle", 32'(busy1), 32'h0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
